// File: rtl/cnn_upsampling_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cnn_upsampling_frame_ctrl_pkg
// Shared definitions for the frame-level sequencer that wraps the
// nearest-neighbour upsampler: FSM state encoding, default geometry and a
// helper that sizes counters able to hold the value N itself.
// ---------------------------------------------------------------------------
package cnn_upsampling_frame_ctrl_pkg;

  // Frame sequencer states (3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_e;

  // Default geometry of the production configuration.
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_IMAGE_WIDTH  = 16;
  localparam int DEF_IMAGE_HEIGHT = 16;
  localparam int DEF_CHANNEL_NUM  = 256;
  localparam int DEF_UP_FACTOR    = 4;
  localparam int DEF_FLUSH_CYCLES = 4;

  // Bits needed for a counter that must be able to represent n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cnn_upsampling_frame_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_upsampling_frame_ctrl
// Frame sequencer placed around a single-frame nearest-neighbour upsampler.
// Each start admits exactly one frame of IN_COUNT pixels (channel-major),
// holds upstream off while the upsampler drains, counts the OUT_COUNT
// upsampled pixels and pulses frame_done once the last one has left.
// The upsampler's synchronous reset is driven high while idle and for
// FLUSH_CYCLES cycles before every frame so its pointers start clean.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous reset, active low
//   start         in   accept next frame (sampled in IDLE/DONE only)
//   valid_in      in   upstream pixel valid
//   pxl_in        in   upstream pixel
//   ready_in      out  high only while loading a frame
//   up_reset      out  upsampler sync reset, active high
//   up_valid      out  upsampler input valid (registered)
//   up_pxl        out  upsampler input pixel (registered)
//   up_valid_out  in   upsampler output valid
//   up_pxl_out    in   upsampler output pixel
//   valid_out     out  downstream pixel valid (registered)
//   pxl_out       out  downstream pixel (registered)
//   busy          out  sequencer not idle
//   frame_done    out  one-cycle pulse, high during DONE
//   err_overflow  out  sticky: a pixel was offered while ready_in was low
// ---------------------------------------------------------------------------
module cnn_upsampling_frame_ctrl
  import cnn_upsampling_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM  = DEF_CHANNEL_NUM,
  parameter int UP_FACTOR    = DEF_UP_FACTOR,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic                  ready_in,
  output logic                  up_reset,
  output logic                  up_valid,
  output logic [DATA_WIDTH-1:0] up_pxl,
  input  logic                  up_valid_out,
  input  logic [DATA_WIDTH-1:0] up_pxl_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_overflow
);

  localparam int IN_COUNT  = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
  localparam int OUT_COUNT = IN_COUNT * UP_FACTOR * UP_FACTOR;
  localparam int IN_CW     = cnt_width(IN_COUNT);
  localparam int OUT_CW    = cnt_width(OUT_COUNT);
  localparam int FLUSH_CW  = cnt_width(FLUSH_CYCLES);

  localparam logic [IN_CW-1:0]    IN_LAST    = IN_CW'(IN_COUNT - 1);
  localparam logic [OUT_CW-1:0]   OUT_LAST   = OUT_CW'(OUT_COUNT - 1);
  localparam logic [FLUSH_CW-1:0] FLUSH_LAST = FLUSH_CW'(FLUSH_CYCLES - 1);

  frame_state_e          state_q;
  frame_state_e          state_d;
  logic [IN_CW-1:0]      in_cnt;
  logic [OUT_CW-1:0]     out_cnt;
  logic [FLUSH_CW-1:0]   flush_cnt;

  logic                  accept;
  logic                  out_take;
  logic                  overflow_hit;
  logic                  ready_d;
  logic                  up_reset_d;
  logic                  done_d;

  // ready_in is a registered copy of (state == LOAD), so gating accepts with
  // it is the same as gating with the state but keeps the port glitch-free.
  assign accept       = valid_in & ready_in;
  assign overflow_hit = valid_in & ~ready_in;
  // The upsampler starts emitting before the frame is fully loaded, so the
  // output path is live in LOAD as well as DRAIN.
  assign out_take     = up_valid_out & ((state_q == ST_LOAD) | (state_q == ST_DRAIN));
  assign busy         = (state_q != ST_IDLE);

  // ---- next-state and registered-output decode ----
  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    up_reset_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && (in_cnt == IN_LAST)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_take && (out_cnt == OUT_LAST)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = start ? ST_FLUSH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it.
    ready_d    = (state_d == ST_LOAD);
    up_reset_d = (state_d == ST_IDLE) | (state_d == ST_FLUSH);
    done_d     = (state_d == ST_DONE);
  end

  // ---- state register and control outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ready_in     <= 1'b0;
      up_reset     <= 1'b1;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_in   <= ready_d;
      up_reset   <= up_reset_d;
      frame_done <= done_d;
      if (overflow_hit) err_overflow <= 1'b1;
    end
  end

  // ---- frame counters ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
    end else if (state_q == ST_FLUSH) begin
      flush_cnt <= flush_cnt + 1'b1;
      in_cnt    <= '0;
      out_cnt   <= '0;
    end else begin
      flush_cnt <= '0;
      if (accept)   in_cnt  <= in_cnt + 1'b1;
      if (out_take) out_cnt <= out_cnt + 1'b1;
    end
  end

  // ---- input stage: one register between upstream and upsampler ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_valid <= 1'b0;
      up_pxl   <= '0;
    end else begin
      up_valid <= accept;
      if (accept) up_pxl <= pxl_in;
    end
  end

  // ---- output stage: one register between upsampler and downstream ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      pxl_out   <= '0;
    end else begin
      valid_out <= out_take;
      if (out_take) pxl_out <= up_pxl_out;
    end
  end

endmodule

// File: tb/tb_cnn_upsampling_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cnn_upsampling_frame_ctrl
// Directed bench for the frame sequencer with a small behavioural stand-in
// for the upsampler: every pixel it receives is emitted UP*UP times in a row.
// Geometry W=2,H=2,C=2,UP=4,FLUSH=4 -> 8 input and 128 output pixels.
// ---------------------------------------------------------------------------
module tb_cnn_upsampling_frame_ctrl;

  localparam int DW   = 32;
  localparam int IN_N = 8;
  localparam int UPSQ = 16;
  localparam int OUTN = 128;
  localparam int FL   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pxl_in = '0;
  logic          ready_in;
  logic          up_reset;
  logic          up_valid;
  logic [DW-1:0] up_pxl;
  logic          up_valid_out;
  logic [DW-1:0] up_pxl_out;
  logic          valid_out;
  logic [DW-1:0] pxl_out;
  logic          busy;
  logic          frame_done;
  logic          err_overflow;

  always #5 clk = ~clk;

  cnn_upsampling_frame_ctrl #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (2),
    .IMAGE_HEIGHT(2),
    .CHANNEL_NUM (2),
    .UP_FACTOR   (4),
    .FLUSH_CYCLES(FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .valid_in    (valid_in),
    .pxl_in      (pxl_in),
    .ready_in    (ready_in),
    .up_reset    (up_reset),
    .up_valid    (up_valid),
    .up_pxl      (up_pxl),
    .up_valid_out(up_valid_out),
    .up_pxl_out  (up_pxl_out),
    .valid_out   (valid_out),
    .pxl_out     (pxl_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_overflow(err_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Upsampler stand-in, evaluated on the falling edge so it never races the
  // DUT's rising-edge registers.
  logic [DW-1:0] fq[$];
  int            frep = 0;
  logic          fu_vld = 1'b0;
  logic [DW-1:0] fu_pxl = '0;
  logic          spur = 1'b0;

  assign up_valid_out = fu_vld | spur;
  assign up_pxl_out   = fu_pxl;

  initial begin
    forever begin
      @(negedge clk);
      if (up_reset) begin
        fq.delete();
        frep   = 0;
        fu_vld = 1'b0;
      end else begin
        if (fq.size() > 0) begin
          fu_vld = 1'b1;
          fu_pxl = fq[0];
          if (frep == UPSQ - 1) begin
            void'(fq.pop_front());
            frep = 0;
          end else begin
            frep++;
          end
        end else begin
          fu_vld = 1'b0;
        end
        if (up_valid) fq.push_back(up_pxl);
      end
    end
  end

  // Expected downstream stream: written by the driver, consumed by the monitor.
  logic [DW-1:0] exp_mem[0:2047];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            out_total = 0;
  int            done_total = 0;
  int            flush_total = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        rd_ptr = wr_ptr;
      end else begin
        if (valid_out) begin
          out_total++;
          check("out_expected", 64'(rd_ptr < wr_ptr), 1);
          if (rd_ptr < wr_ptr) begin
            check("pxl_out", pxl_out, exp_mem[rd_ptr]);
            rd_ptr++;
          end
        end
        if (frame_done) done_total++;
        if (busy && up_reset) flush_total++;
      end
    end
  end

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({tag, "_ready"},  ready_in, 0);
    check({tag, "_upres"},  up_reset, 1);
    check({tag, "_upvld"},  up_valid, 0);
    check({tag, "_uppxl"},  up_pxl, 0);
    check({tag, "_vout"},   valid_out, 0);
    check({tag, "_pout"},   pxl_out, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   frame_done, 0);
    check({tag, "_err"},    err_overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_rel_busy"},  busy, 0);
    check({tag, "_rel_upres"}, up_reset, 1);
    check({tag, "_rel_ready"}, ready_in, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready_in && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready_wait"}, ready_in, 1);
  endtask

  task automatic drive_px(input logic [DW-1:0] v, input int gap);
    check("ready_px", ready_in, 1);
    valid_in = 1'b1;
    pxl_in   = v;
    for (int r = 0; r < UPSQ; r++) begin
      exp_mem[wr_ptr] = v;
      wr_ptr++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!frame_done && k < 600) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, frame_done, 1);
    @(negedge clk);
    check({tag, "_pulse"}, frame_done, 0);
  endtask

  // hold: start is already held high by the caller; release: drop it once
  // the frame is loading; drain_vin: offer one illegal pixel during DRAIN.
  task automatic run_frame(input string tag, input logic [DW-1:0] base, input int gap,
                           input bit hold, input bit release_start, input bit drain_vin);
    int o0 = out_total;
    int d0 = done_total;
    int f0 = flush_total;
    if (!hold) pulse_start();
    wait_ready(tag);
    if (release_start) start = 1'b0;
    for (int i = 0; i < IN_N; i++) drive_px(base + DW'(i), (i == IN_N - 1) ? 0 : gap);
    check({tag, "_ready_drop"}, ready_in, 0);
    if (drain_vin) begin
      valid_in = 1'b1;
      pxl_in   = 32'hBAD0;
      @(negedge clk);
      valid_in = 1'b0;
      check({tag, "_err_drain"}, err_overflow, 1);
    end
    wait_done(tag);
    check({tag, "_outs"},  out_total - o0, OUTN);
    check({tag, "_dones"}, done_total - d0, 1);
    if (!hold) begin
      check({tag, "_flush"}, flush_total - f0, FL);
      check({tag, "_busy"},  busy, 0);
    end
  endtask

  initial begin
    int o0;
    int f0;

    // 1: power-up reset, then reset in the middle of a frame
    do_reset("rst0");
    pulse_start();
    wait_ready("s1");
    for (int i = 0; i < 3; i++) drive_px(32'hA0 + DW'(i), 0);
    do_reset("rst1");

    // 2: single frame, back-to-back input
    run_frame("f2", 32'h10, 0, 1'b0, 1'b0, 1'b0);

    // 3: start held across two frames
    f0 = flush_total;
    @(negedge clk);
    start = 1'b1;
    run_frame("f3a", 32'd1, 0, 1'b1, 1'b0, 1'b0);
    run_frame("f3b", 32'd9, 0, 1'b1, 1'b1, 1'b0);
    check("f3_flush", flush_total - f0, 2 * FL);
    check("f3_busy", busy, 0);
    check("f3_err", err_overflow, 0);

    // 4: illegal pixel during DRAIN, then in IDLE with a stray upsampler valid
    run_frame("f4", 32'h40, 0, 1'b0, 1'b0, 1'b1);
    check("f4_err_sticky", err_overflow, 1);
    do_reset("rst4");
    o0 = out_total;
    spur     = 1'b1;
    valid_in = 1'b1;
    pxl_in   = 32'hDEAD;
    @(negedge clk);
    check("idle_vout0", valid_out, 0);
    @(negedge clk);
    check("idle_vout1", valid_out, 0);
    spur     = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check("idle_err", err_overflow, 1);
    check("idle_busy", busy, 0);
    check("idle_outs", out_total - o0, 0);

    // 5: gapped input, one pixel every third cycle
    run_frame("f5", 32'h50, 2, 1'b0, 1'b0, 1'b0);
    check("f5_err_sticky", err_overflow, 1);

    // 6: reset after five inputs, then a clean frame
    pulse_start();
    wait_ready("s6");
    for (int i = 0; i < 5; i++) drive_px(32'h60 + DW'(i), 0);
    do_reset("rst6");
    run_frame("f6", 32'h70, 0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("f6_no_stale", rd_ptr, wr_ptr);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
